bus_capture_fifo: RTL and testbench

//   Capture stage directly upstream of the bus comparator; one instance per redundant bus channel.
//   - Samples qualified words from a single channel.
//   - Stamps each word with a free-running cycle timestamp.
//   - Buffers words in a show-ahead FIFO; comparator pops via valid/ready.
//   - Reports fill level, overflow and dropped-word count so the comparator can initialise/flush state.

---
 rtl/bus_capture_fifo.sv | 76 +++++++
 tb/tb_bus_capture_fifo.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_capture_fifo.sv
// bus_capture_fifo: timestamped show-ahead capture FIFO for one redundant bus channel
// Define BUS_CAPTURE_PARITY_EN to add per-entry even-parity error tracking (bus_par/out_perr).
module bus_capture_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int TS_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_valid,
    input  logic [DATA_W-1:0] bus_data,
`ifdef BUS_CAPTURE_PARITY_EN
    input  logic              bus_par,
    output logic              out_perr,
`endif
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TS_W-1:0]   out_ts,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic [7:0]        drop_cnt
);
    logic [DATA_W+TS_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]        wr_ptr, rd_ptr;
    logic [TS_W-1:0]        ts_cnt;
    logic                   push, pop, drop;

    assign empty     = wr_ptr == rd_ptr;
    assign full      = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) && (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign count     = wr_ptr - rd_ptr;
    assign out_valid = !empty;
    assign push      = bus_valid && !full;
    assign drop      = bus_valid && full;
    assign pop       = !empty && out_ready;
    // Head is forced to zero while empty so stale memory never leaks out after reset/flush
    assign {out_data, out_ts} = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];

    always_ff @(posedge clk)
        if (push && !flush) mem[wr_ptr[ADDR_W-1:0]] <= {bus_data, ts_cnt};

`ifdef BUS_CAPTURE_PARITY_EN
    logic perr_mem [DEPTH];
    assign out_perr = !empty && perr_mem[rd_ptr[ADDR_W-1:0]];
    always_ff @(posedge clk)
        if (push && !flush) perr_mem[wr_ptr[ADDR_W-1:0]] <= ^{bus_data, bus_par};
`endif

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ts_cnt   <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                overflow <= 1'b0;
                drop_cnt <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                if (drop) begin
                    overflow <= 1'b1;
                    drop_cnt <= drop_cnt + 8'(drop_cnt != 8'hff);
                end
            end
        end
endmodule

// File: tb/tb_bus_capture_fifo.sv
// tb_bus_capture_fifo: directed checks of bus_capture_fifo (TS_W shrunk so timestamp wrap is reachable)
module tb_bus_capture_fifo;
    localparam int DW = 16, DEPTH = 16, AW = 4, TW = 5;
    typedef struct packed {logic [DW-1:0] d; logic [TW-1:0] t;} ent_t;

    logic clk = 0, rst = 0, bus_valid = 0, flush = 0, out_ready = 0;
    logic [DW-1:0] bus_data = '0;
    logic out_valid, full, empty, overflow;
    logic [DW-1:0] out_data;
    logic [TW-1:0] out_ts, mts, t_save;
    logic [AW:0] count;
    logic [7:0] drop_cnt;
`ifdef BUS_CAPTURE_PARITY_EN
    logic bus_par = 0, out_perr;
`endif
    int n_chk = 0, n_fail = 0, exp_drop;
    logic push_ok;
    ent_t q[$];

    bus_capture_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .TS_W(TW)) dut (
        .clk(clk), .rst(rst), .bus_valid(bus_valid), .bus_data(bus_data),
`ifdef BUS_CAPTURE_PARITY_EN
        .bus_par(bus_par), .out_perr(out_perr),
`endif
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ts(out_ts), .count(count), .full(full), .empty(empty), .overflow(overflow),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk or negedge rst) mts <= !rst ? '0 : mts + 1'b1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_data", {out_data, out_ts}, 0);
        #10 rst = 1;
        // latency and order
        for (int k = 0; k < 20 && mts != 5; k++) step();
        chk("t2_ts_reach", mts, 5);
        bus_valid = 1; bus_data = 16'h1111; out_ready = 1;
        chk("t2_no_bypass", out_valid, 0);
        step();
        chk("t2_valid", out_valid, 1);
        chk("t2_head0", out_data, 16'h1111);
        chk("t2_ts0", out_ts, 5);
        bus_data = 16'h2222;
        step();
        bus_valid = 0;
        chk("t2_head1", out_data, 16'h2222);
        chk("t2_ts1", out_ts, 6);
        chk("t2_count", count, 1);
        step();
        chk("t2_empty", empty, 1);
        out_ready = 0;
        // full and overflow
        for (int i = 0; i < 18; i++) begin
            if (i == 16) begin
                chk("t3_full16", full, 1);
                chk("t3_ovf16", overflow, 0);
            end
            bus_valid = 1; bus_data = 16'h3000 + 16'(i);
            step();
        end
        bus_valid = 0;
        chk("t3_full", full, 1);
        chk("t3_count", count, 16);
        chk("t3_ovf", overflow, 1);
        chk("t3_drop", drop_cnt, 2);
        chk("t3_head", out_data, 16'h3000);
        // full + push + pop: push dropped
        bus_valid = 1; bus_data = 16'hdead; out_ready = 1;
        step();
        bus_valid = 0; out_ready = 0;
        chk("t4a_count", count, 15);
        chk("t4a_drop", drop_cnt, 3);
        chk("t4a_full", full, 0);
        out_ready = 1;
        for (int i = 0; i < 15; i++) begin
            chk("t4a_drain", out_data, 16'h3001 + 16'(i));
            step();
        end
        chk("t4a_empty", empty, 1);
        step();
        chk("t4a_underflow", count, 0);
        out_ready = 0;
        // count 8 + push + pop
        for (int i = 0; i < 8; i++) begin
            bus_valid = 1; bus_data = 16'h4000 + 16'(i);
            step();
        end
        chk("t4b_count8", count, 8);
        bus_data = 16'h4008; out_ready = 1;
        step();
        bus_valid = 0; out_ready = 0;
        chk("t4b_count", count, 8);
        chk("t4b_head", out_data, 16'h4001);
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            chk("t4b_drain", out_data, 16'h4001 + 16'(i));
            step();
        end
        out_ready = 0;
        chk("t4b_empty", empty, 1);
        // random stream across pointer and timestamp wrap
        exp_drop = 3;
        for (int i = 0; i < 60; i++) begin
            bus_valid = i < 40; bus_data = 16'($urandom); out_ready = 1'($urandom_range(0, 1));
            chk("t5_valid", out_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("t5_data", out_data, q[0].d);
                chk("t5_ts", out_ts, q[0].t);
            end
            chk("t5_count", count, q.size());
            chk("t5_drop", drop_cnt, exp_drop);
            push_ok = bus_valid && q.size() < DEPTH;
            if (bus_valid && q.size() == DEPTH) exp_drop++;
            if (out_ready && q.size() != 0) void'(q.pop_front());
            if (push_ok) q.push_back(ent_t'({bus_data, mts}));
            step();
        end
        // drop counter saturation
        out_ready = 0; bus_valid = 1;
        for (int i = 0; i < 300; i++) step();
        bus_valid = 0;
        chk("sat_drop", drop_cnt, 255);
        chk("sat_count", count, 16);
        chk("sat_ovf", overflow, 1);
        chk("sat_head", out_data, q[0].d);
        // reset mid-transfer
        bus_valid = 1; bus_data = 16'h5555;
        #2 rst = 0;
        #1;
        chk("t1_valid", out_valid, 0);
        chk("t1_empty", empty, 1);
        chk("t1_count", count, 0);
        chk("t1_ovf", overflow, 0);
        chk("t1_drop", drop_cnt, 0);
        chk("t1_data", {out_data, out_ts}, 0);
        bus_valid = 0;
        #3 rst = 1;
        step();
        chk("t1_after", empty, 1);
        // flush with bus_valid high
        for (int i = 0; i < 17; i++) begin
            bus_valid = 1; bus_data = 16'h6000 + 16'(i);
            step();
        end
        chk("fl_pre_drop", drop_cnt, 1);
        flush = 1; out_ready = 1;
        step();
        flush = 0; bus_valid = 0; out_ready = 0;
        chk("fl_count", count, 0);
        chk("fl_empty", empty, 1);
        chk("fl_ovf", overflow, 0);
        chk("fl_drop", drop_cnt, 0);
        chk("fl_full", full, 0);
        bus_valid = 1; bus_data = 16'habcd; t_save = mts;
        step();
        bus_valid = 0;
        chk("fl_post_data", out_data, 16'habcd);
        chk("fl_post_ts", out_ts, t_save);
        out_ready = 1;
        step();
        out_ready = 0;
`ifdef BUS_CAPTURE_PARITY_EN
        bus_valid = 1; bus_data = 16'h0001; bus_par = 0;
        step();
        bus_par = 1;
        step();
        bus_valid = 0;
        chk("t6_perr1", out_perr, 1);
        out_ready = 1;
        step();
        out_ready = 0;
        chk("t6_perr0", out_perr, 0);
        chk("t6_data", out_data, 16'h0001);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
